// File: rtl/data_memory_arbiter_if.sv
// Bundle of the CPU, DMA and data-memory signals around the data memory arbiter.
// The arbiter takes the slave view; requesters and memory take the master view.
interface data_memory_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  cpu_req;
    logic                  cpu_we;
    logic [ADDR_WIDTH-1:0] cpu_addr;
    logic [DATA_WIDTH-1:0] cpu_wdata;
    logic [DATA_WIDTH-1:0] cpu_rdata;
    logic                  cpu_ack;
    logic                  cpu_stall;
    logic                  dma_req;
    logic                  dma_we;
    logic [ADDR_WIDTH-1:0] dma_addr;
    logic [DATA_WIDTH-1:0] dma_wdata;
    logic [DATA_WIDTH-1:0] dma_rdata;
    logic                  dma_ack;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_read;
    logic                  mem_write;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  grant_dma;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        input  mem_rdata,
        output cpu_rdata, cpu_ack, cpu_stall,
        output dma_rdata, dma_ack,
        output mem_addr, mem_wdata, mem_read, mem_write,
        output grant_dma
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output dma_req, dma_we, dma_addr, dma_wdata,
        output mem_rdata,
        input  cpu_rdata, cpu_ack, cpu_stall,
        input  dma_rdata, dma_ack,
        input  mem_addr, mem_wdata, mem_read, mem_write,
        input  grant_dma
    );
endinterface

// File: rtl/data_memory_arbiter.sv
// Shares the single-port data memory between the CPU MEM stage and a DMA port:
// CPU priority, bounded DMA starvation, fixed-length access window, stall until CPU ack.
module data_memory_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int MEM_LATENCY  = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    data_memory_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

    localparam logic [1:0] LAST_WIN   = 2'(MEM_LATENCY - 1);
    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    state_e                state_q, state_d;
    logic [3:0]            starveCnt_q, starveCnt_d;
    logic [1:0]            winCnt_q, winCnt_d;
    logic                  grantDma_q, grantDma_d;
    logic                  memRead_q, memRead_d;
    logic                  memWrite_q, memWrite_d;
    logic [ADDR_WIDTH-1:0] memAddr_q, memAddr_d;
    logic [DATA_WIDTH-1:0] memWdata_q, memWdata_d;
    logic                  cpuAck_q, cpuAck_d;
    logic                  dmaAck_q, dmaAck_d;
    logic [DATA_WIDTH-1:0] cpuRdata_q, cpuRdata_d;
    logic [DATA_WIDTH-1:0] dmaRdata_q, dmaRdata_d;
    logic                  dmaWins;

    // The memory strobes double as the latched operands, so no separate copy of we is kept.
    always_comb begin
        dmaWins     = bus.dma_req & (~bus.cpu_req | (starveCnt_q == STARVE_MAX));
        state_d     = state_q;
        starveCnt_d = starveCnt_q;
        winCnt_d    = winCnt_q;
        grantDma_d  = grantDma_q;
        memRead_d   = memRead_q;
        memWrite_d  = memWrite_q;
        memAddr_d   = memAddr_q;
        memWdata_d  = memWdata_q;
        cpuAck_d    = 1'b0;
        dmaAck_d    = 1'b0;
        cpuRdata_d  = cpuRdata_q;
        dmaRdata_d  = dmaRdata_q;
        case (state_q)
            IDLE: begin
                if (dmaWins) begin
                    state_d     = ACCESS;
                    winCnt_d    = 2'd0;
                    grantDma_d  = 1'b1;
                    memRead_d   = ~bus.dma_we;
                    memWrite_d  = bus.dma_we;
                    memAddr_d   = bus.dma_addr;
                    memWdata_d  = bus.dma_wdata;
                    starveCnt_d = 4'd0;
                end else if (bus.cpu_req) begin
                    state_d     = ACCESS;
                    winCnt_d    = 2'd0;
                    grantDma_d  = 1'b0;
                    memRead_d   = ~bus.cpu_we;
                    memWrite_d  = bus.cpu_we;
                    memAddr_d   = bus.cpu_addr;
                    memWdata_d  = bus.cpu_wdata;
                    starveCnt_d = !bus.dma_req ? 4'd0 :
                                  (starveCnt_q == STARVE_MAX) ? STARVE_MAX : starveCnt_q + 4'd1;
                end
            end
            ACCESS: begin
                if (winCnt_q == LAST_WIN) begin
                    if (memRead_q) begin
                        if (grantDma_q) dmaRdata_d = bus.mem_rdata;
                        else            cpuRdata_d = bus.mem_rdata;
                    end
                    memRead_d  = 1'b0;
                    memWrite_d = 1'b0;
                    memAddr_d  = '0;
                    memWdata_d = '0;
                    cpuAck_d   = ~grantDma_q;
                    dmaAck_d   = grantDma_q;
                    state_d    = RESP;
                end else begin
                    winCnt_d = winCnt_q + 2'd1;
                end
            end
            RESP: begin
                grantDma_d = 1'b0;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Reset wins over everything, including an access already in flight.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            starveCnt_q <= 4'd0;
            winCnt_q    <= 2'd0;
            grantDma_q  <= 1'b0;
            memRead_q   <= 1'b0;
            memWrite_q  <= 1'b0;
            memAddr_q   <= '0;
            memWdata_q  <= '0;
            cpuAck_q    <= 1'b0;
            dmaAck_q    <= 1'b0;
            cpuRdata_q  <= '0;
            dmaRdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            starveCnt_q <= starveCnt_d;
            winCnt_q    <= winCnt_d;
            grantDma_q  <= grantDma_d;
            memRead_q   <= memRead_d;
            memWrite_q  <= memWrite_d;
            memAddr_q   <= memAddr_d;
            memWdata_q  <= memWdata_d;
            cpuAck_q    <= cpuAck_d;
            dmaAck_q    <= dmaAck_d;
            cpuRdata_q  <= cpuRdata_d;
            dmaRdata_q  <= dmaRdata_d;
        end
    end

    assign bus.mem_addr  = memAddr_q;
    assign bus.mem_wdata = memWdata_q;
    assign bus.mem_read  = memRead_q;
    assign bus.mem_write = memWrite_q;
    assign bus.cpu_ack   = cpuAck_q;
    assign bus.dma_ack   = dmaAck_q;
    assign bus.cpu_rdata = cpuRdata_q;
    assign bus.dma_rdata = dmaRdata_q;
    assign bus.grant_dma = grantDma_q;
    assign bus.cpu_stall = bus.cpu_req & ~cpuAck_q;
endmodule
